traffic_light_ctrl_n: RTL and testbench



---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_light_ctrl_n_tick_gen.sv | 31 +++
 rtl/traffic_light_ctrl_n.sv | 225 ++++++++++++++++++++++
 tb/tb_traffic_light_ctrl_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the main/side-road traffic light controller.
// FLASH exists in the state type only when NIGHT_FLASH_EN is defined.
package traffic_pkg;

   localparam int TIMER_W = 8;

   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;
   localparam logic [2:0] LIGHT_OFF = 3'b000;

`ifdef NIGHT_FLASH_EN
   typedef enum logic [2:0] {
      ALLRED_M,
      MAIN_GREEN,
      MAIN_YELLOW,
      ALLRED_S,
      SIDE_GREEN,
      SIDE_YELLOW,
      FLASH
   } state_t;
`else
   typedef enum logic [2:0] {
      ALLRED_M,
      MAIN_GREEN,
      MAIN_YELLOW,
      ALLRED_S,
      SIDE_GREEN,
      SIDE_YELLOW
   } state_t;
`endif

   typedef logic [TIMER_W-1:0] timer_t;

   // A state lasting 'secs' ticks is entered with the timer at secs-1.
   function automatic timer_t dur_load(input int secs);
      return timer_t'(secs - 1);
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_tick_gen.sv
// Seconds prescaler: counts 0..CLK_DIV-1 and pulses sec_tick on the last count.
module tick_gen #(
   parameter int CLK_DIV = 100000000
) (
   input  logic clk_in1,
   input  logic rst,
   output logic sec_tick
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_chk_div
      $error("tick_gen: CLK_DIV must be at least 2");
   end

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_in1 or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign sec_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// Main road / N side-road traffic light controller with round-robin side service.
// Optional night flashing mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_light_ctrl_n
   import traffic_pkg::*;
#(
   parameter int N_SIDE     = 2,
   parameter int CLK_DIV    = 100000000,
   parameter int T_MAIN_MIN = 25,
   parameter int T_SIDE_MIN = 5,
   parameter int T_SIDE_MAX = 15,
   parameter int T_YELLOW   = 4,
   parameter int T_ALLRED   = 1
) (
   input  logic                  clk_in1,
   input  logic                  rst,
   input  logic [N_SIDE-1:0]     car_req,
`ifdef NIGHT_FLASH_EN
   input  logic                  night,
`endif
   output logic [2:0]            main_light,
   output logic [3*N_SIDE-1:0]   side_light,
   output logic [7:0]            countdown,
   output logic                  sec_tick
);

   localparam int SEL_W = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;
   localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(N_SIDE - 1);

   localparam timer_t LD_ALLRED   = dur_load(T_ALLRED);
   localparam timer_t LD_MAIN     = dur_load(T_MAIN_MIN);
   localparam timer_t LD_YELLOW   = dur_load(T_YELLOW);
   localparam timer_t LD_SIDE_MAX = dur_load(T_SIDE_MAX);
   localparam timer_t SIDE_EARLY  = timer_t'(T_SIDE_MAX - T_SIDE_MIN);

   if (N_SIDE < 1 || N_SIDE > 8) begin : g_chk_nside
      $error("traffic_light_ctrl_n: N_SIDE must be 1..8");
   end
   if (T_MAIN_MIN < 1 || T_MAIN_MIN > 255 || T_SIDE_MIN < 1 || T_SIDE_MIN > 255 ||
       T_SIDE_MAX < 1 || T_SIDE_MAX > 255 || T_YELLOW < 1 || T_YELLOW > 255 ||
       T_ALLRED < 1 || T_ALLRED > 255) begin : g_chk_times
      $error("traffic_light_ctrl_n: T_* parameters must be 1..255");
   end
   if (T_SIDE_MAX < T_SIDE_MIN) begin : g_chk_side
      $error("traffic_light_ctrl_n: T_SIDE_MAX must be >= T_SIDE_MIN");
   end

   // First pending side strictly after cur, searching upward and wrapping.
   function automatic logic [SEL_W-1:0] rr_next(input logic [N_SIDE-1:0] req,
                                                input logic [SEL_W-1:0]  cur);
      logic [SEL_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = cur;
      found = 1'b0;
      for (int k = 1; k <= N_SIDE; k++) begin
         idx = (int'(cur) + k) % N_SIDE;
         if (!found && req[idx]) begin
            pick  = SEL_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   logic tick;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk_in1  (clk_in1),
      .rst      (rst),
      .sec_tick (tick)
   );

   state_t                 state, state_n;
   timer_t                 timer, timer_n;
   logic [N_SIDE-1:0]      pending, pending_n;
   logic [SEL_W-1:0]       sel, sel_n;
   logic [2:0]             main_n;
   logic [3*N_SIDE-1:0]    side_n;
   logic                   expired;
   logic                   enter_side;
`ifdef NIGHT_FLASH_EN
   logic                   flash_ph, flash_n;
`endif

   assign expired = (timer == '0);

   always_ff @(posedge clk_in1 or posedge rst) begin
      if (rst) begin
         state      <= ALLRED_M;
         timer      <= LD_ALLRED;
         pending    <= '0;
         sel        <= SEL_RST;
         main_light <= LIGHT_RED;
         side_light <= {N_SIDE{LIGHT_RED}};
`ifdef NIGHT_FLASH_EN
         flash_ph   <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         pending    <= pending_n;
         sel        <= sel_n;
         main_light <= main_n;
         side_light <= side_n;
`ifdef NIGHT_FLASH_EN
         flash_ph   <= flash_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      sel_n      = sel;
      pending_n  = pending | car_req;
      enter_side = 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_n    = flash_ph;
`endif

      if (tick) begin
         if (!expired) begin
            timer_n = timer - timer_t'(1);
         end
         unique case (state)
            ALLRED_M: begin
               if (expired) begin
                  state_n = MAIN_GREEN;
                  timer_n = LD_MAIN;
               end
            end
            MAIN_GREEN: begin
               // Timer parks at zero; leave only once someone is waiting.
               if (expired && (pending != '0)) begin
                  state_n = MAIN_YELLOW;
                  timer_n = LD_YELLOW;
                  sel_n   = rr_next(pending, sel);
               end
            end
            MAIN_YELLOW: begin
               if (expired) begin
                  state_n = ALLRED_S;
                  timer_n = LD_ALLRED;
               end
            end
            ALLRED_S: begin
               if (expired) begin
                  state_n    = SIDE_GREEN;
                  timer_n    = LD_SIDE_MAX;
                  enter_side = 1'b1;
               end
            end
            SIDE_GREEN: begin
               if (expired || (!car_req[sel] && (timer <= SIDE_EARLY))) begin
                  state_n = SIDE_YELLOW;
                  timer_n = LD_YELLOW;
               end
            end
            SIDE_YELLOW: begin
               if (expired) begin
                  state_n = ALLRED_M;
                  timer_n = LD_ALLRED;
               end
            end
            default: ;
         endcase
      end

      if (enter_side) begin
         pending_n[sel] = 1'b0;
      end

`ifdef NIGHT_FLASH_EN
      if (night) begin
         state_n   = FLASH;
         timer_n   = '0;
         sel_n     = sel;
         pending_n = '0;
         if (tick) begin
            flash_n = ~flash_ph;
         end
      end else if (state == FLASH) begin
         state_n = ALLRED_M;
         timer_n = LD_ALLRED;
      end
`endif
   end

   // Lights are decoded from the next state so they register alongside it.
   always_comb begin
      main_n = LIGHT_RED;
      side_n = {N_SIDE{LIGHT_RED}};
      unique case (state_n)
         MAIN_GREEN:  main_n = LIGHT_GRN;
         MAIN_YELLOW: main_n = LIGHT_YEL;
         SIDE_GREEN: begin
            for (int i = 0; i < N_SIDE; i++) begin
               if (SEL_W'(i) == sel_n) begin
                  side_n[3*i +: 3] = LIGHT_GRN;
               end
            end
         end
         SIDE_YELLOW: begin
            for (int i = 0; i < N_SIDE; i++) begin
               if (SEL_W'(i) == sel_n) begin
                  side_n[3*i +: 3] = LIGHT_YEL;
               end
            end
         end
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            main_n = flash_n ? LIGHT_YEL : LIGHT_OFF;
            side_n = {N_SIDE{flash_n ? LIGHT_YEL : LIGHT_OFF}};
         end
`endif
         default: ;
      endcase
   end

   assign countdown = timer;
   assign sec_tick  = tick;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Scoreboard bench for traffic_light_ctrl_n: a phase/elapsed-seconds model predicts
// the lights and countdown after every second tick; a monitor checks each DUT tick.
module tb_traffic_light_ctrl_n;

   localparam int N     = 2;
   localparam int DIV   = 4;
   localparam int TMM   = 5;
   localparam int TSMIN = 2;
   localparam int TSMAX = 6;
   localparam int TY    = 2;
   localparam int TAR   = 1;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic          clk_in1 = 1'b0;
   logic          rst;
   logic [N-1:0]  car_req;
   logic          night;
   logic [2:0]    main_light;
   logic [3*N-1:0] side_light;
   logic [7:0]    countdown;
   logic          sec_tick;

   always #5 clk_in1 = ~clk_in1;

   traffic_light_ctrl_n #(
      .N_SIDE     (N),
      .CLK_DIV    (DIV),
      .T_MAIN_MIN (TMM),
      .T_SIDE_MIN (TSMIN),
      .T_SIDE_MAX (TSMAX),
      .T_YELLOW   (TY),
      .T_ALLRED   (TAR)
   ) dut (
      .clk_in1    (clk_in1),
      .rst        (rst),
      .car_req    (car_req),
`ifdef NIGHT_FLASH_EN
      .night      (night),
`endif
      .main_light (main_light),
      .side_light (side_light),
      .countdown  (countdown),
      .sec_tick   (sec_tick)
   );

   typedef struct packed {
      logic [2:0]     m;
      logic [3*N-1:0] s;
      logic [7:0]     cd;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: which road phase we are in and how many whole seconds it has run.
   typedef enum {P_ARM, P_MG, P_MY, P_ARS, P_SG, P_SY} phase_e;
   phase_e      ph;
   int          el;
   int          msel;
   logic [N-1:0] mpend;
   int          mcnt;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.m  = R;
      e.s  = {N{R}};
      e.cd = '0;
      case (ph)
         P_ARM: e.cd = 8'(TAR - 1 - el);
         P_MG: begin
            e.m  = G;
            e.cd = (el >= TMM - 1) ? 8'd0 : 8'(TMM - 1 - el);
         end
         P_MY: begin
            e.m  = Y;
            e.cd = 8'(TY - 1 - el);
         end
         P_ARS: e.cd = 8'(TAR - 1 - el);
         P_SG: begin
            e.s[3*msel +: 3] = G;
            e.cd = 8'(TSMAX - 1 - el);
         end
         P_SY: begin
            e.s[3*msel +: 3] = Y;
            e.cd = 8'(TY - 1 - el);
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic int pick_next(input logic [N-1:0] p, input int cur);
      for (int k = 1; k <= N; k++) begin
         if (p[(cur + k) % N]) return (cur + k) % N;
      end
      return cur;
   endfunction

   task automatic model_reset();
      ph    = P_ARM;
      el    = 0;
      msel  = N - 1;
      mpend = '0;
      mcnt  = 0;
   endtask

   // Advance the model by one clock edge that samples req.
   task automatic model_step(input logic [N-1:0] req);
      bit           tick;
      bit           done;
      bit           enter;
      logic [N-1:0] old;
      phase_e       nxt;
      tick  = (mcnt == DIV - 1);
      old   = mpend;
      enter = 0;
      if (tick) begin
         done = 0;
         nxt  = ph;
         case (ph)
            P_ARM: begin done = (el + 1 >= TAR); nxt = P_MG; end
            P_MG: begin
               done = (el + 1 >= TMM) && (old != '0);
               nxt  = P_MY;
               if (done) msel = pick_next(old, msel);
            end
            P_MY:  begin done = (el + 1 >= TY);  nxt = P_ARS; end
            P_ARS: begin done = (el + 1 >= TAR); nxt = P_SG; enter = done; end
            P_SG: begin
               done = (el + 1 >= TSMAX) || (!req[msel] && (el + 1 >= TSMIN));
               nxt  = P_SY;
            end
            P_SY:  begin done = (el + 1 >= TY);  nxt = P_ARM; end
            default: ;
         endcase
         if (done) begin
            ph = nxt;
            el = 0;
         end else begin
            el++;
         end
      end
      mpend = old | req;
      if (enter) mpend[msel] = 1'b0;
      mcnt = tick ? 0 : mcnt + 1;
      if (tick) exp_q.push_back(expect_now());
   endtask

   task automatic run_cycle(input logic [N-1:0] req);
      @(negedge clk_in1);
      car_req = req;
      if (!rst) model_step(req);
   endtask

   task automatic run_ticks(input logic [N-1:0] req, input int n);
      for (int i = 0; i < n * DIV; i++) run_cycle(req);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_main"}, main_light, R);
      check({tag, "_side"}, side_light, {N{R}});
      check({tag, "_countdown"}, countdown, TAR - 1);
      check({tag, "_sec_tick"}, sec_tick, 0);
   endtask

   // Monitor: every tick the DUT shows must match the next queued prediction.
   initial begin
      logic saw_tick;
      int   nonred;
      exp_t e;
      forever begin
         @(negedge clk_in1);
         saw_tick = sec_tick;
         @(posedge clk_in1);
         #1;
         if (!rst) begin
            nonred = (main_light != R) ? 1 : 0;
            for (int i = 0; i < N; i++) nonred += (side_light[3*i +: 3] != R) ? 1 : 0;
            check("at_most_one_nonred", (nonred <= 1) ? 1 : 0, 1);
            if (saw_tick) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_tick", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  checks++;
                  if (main_light !== e.m || side_light !== e.s || countdown !== e.cd) begin
                     failures++;
                     $display("FAIL tick_state actual main=%b side=%b cd=%0d required main=%b side=%b cd=%0d",
                              main_light, side_light, countdown, e.m, e.s, e.cd);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [N-1:0] rq;
      bit           reached;
      rst     = 1'b1;
      car_req = '0;
      night   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_in1);
      check_reset_outputs("reset");

      @(negedge clk_in1);
      rst = 1'b0;
      model_step('0);

      // Idle: main green must be held with countdown parked at zero.
      run_ticks(2'b00, 12);
      // Side 0 held: full maximum green.
      run_ticks(2'b01, 24);
      run_ticks(2'b00, 10);
      // Side 1 pulsed for a single cycle: latched and served for the minimum.
      run_cycle(2'b10);
      run_ticks(2'b00, 24);
      // Both held: alternating service with main green in between.
      run_ticks(2'b11, 60);
      run_ticks(2'b00, 8);

      // Randomised sensor activity.
      rq = '0;
      for (int i = 0; i < 150 * DIV; i++) begin
         if ($urandom_range(0, 15) == 0) rq = N'($urandom_range(0, 3));
         run_cycle(rq);
      end

      // Reset while side 1 is green.
      reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
         run_cycle(2'b10);
         if (ph == P_SG && msel == 1 && el >= 1) reached = 1;
      end
      check("reach_side1_green", reached, 1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      model_reset();
      repeat (2) run_cycle(2'b00);
      @(negedge clk_in1);
      rst     = 1'b0;
      car_req = 2'b00;
      model_step(2'b00);

      // Restart from all-red, then more random traffic.
      run_ticks(2'b00, 3);
      rq = '0;
      for (int i = 0; i < 60 * DIV; i++) begin
         if ($urandom_range(0, 11) == 0) rq = N'($urandom_range(0, 3));
         run_cycle(rq);
      end
      run_ticks(2'b00, 20);

      @(posedge clk_in1);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
